player_ctrl: RTL
================

# player_ctrl

Player position controller for the maze game. It turns the four push-buttons into a stepped, screen-clamped player position on a fixed move tick. It is the producer of the player_hPos/player_vPos that the destination-rectangle checker compares against, and the consumer of that checker's level_complete. On a win it freezes the player, counts the level, and respawns the player at the start position.

## Interface
- H_LIM, default 632: maximum legal player_hPos (screen width minus player size).
- V_LIM, default 472: maximum legal player_vPos.
- STEP, default 8: pixels moved per tick. All positions are multiples of STEP, so the destination equality compare can hit.
- MOVE_DIV, default 2_000_000: clock cycles per move tick. Must be ≥ 2.
- HOLD_CYCLES, default 50_000_000: length of the win freeze in cycles. Must be ≥ 1.
- H_START, default 0: respawn hPos. Must be a multiple of STEP.
- V_START, default 0: respawn vPos. Must be a multiple of STEP.
- clk  in  1  system clock; the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw, asynchronous, already-debounced buttons.
- level_complete  in  1  combinational hit flag from the destination checker.
- player_hPos  out  12  registered horizontal position.
- player_vPos  out  12  registered vertical position.
- frozen  out  1  high while in WIN_HOLD or RESPAWN.
- new_level  out  1  one-cycle pulse when the player respawns.
- level_count  out  4  completed-level counter; wraps 15 -> 0.

## Operation
- Each button passes through a 2-flop synchronizer. The synchronized values are used everywhere below.
- Tick generator: counter runs 0..MOVE_DIV-1. tick is high for one cycle when the counter equals MOVE_DIV-1, then the counter returns to 0. The counter runs only in PLAY; it is cleared to 0 on entry to WIN_HOLD.
- FSM states are PLAY, WIN_HOLD, RESPAWN.
- PLAY, on tick:
  - Vertical: up alone gives vPos = (vPos ≥ STEP) ? vPos−STEP : 0. down alone gives vPos = (vPos+STEP ≤ V_LIM) ? vPos+STEP : V_LIM. Both or neither pressed: no vertical change.
  - Horizontal: left and right follow the same rule using H_LIM.
  - Horizontal and vertical moves are independent, so diagonal moves are allowed.
  - Arithmetic is 12-bit. The compare uses a 13-bit sum so there is no wrap-around.
- Arming flag `armed`:
  - Set in PLAY whenever level_complete is 0.
  - Cleared on entry to WIN_HOLD.
  - Purpose: a destination placed at the start position cannot retrigger until the player leaves it.
- PLAY with level_complete=1 and armed=1:
  - Next state is WIN_HOLD.
  - level_count increments.
  - Position is frozen; a tick in the same cycle is ignored.
- WIN_HOLD: hold counter counts HOLD_CYCLES cycles. Buttons and level_complete are ignored. Then go to RESPAWN.
- RESPAWN (exactly 1 cycle):
  - Load H_START/V_START.
  - new_level = 1.
  - Next state is PLAY.

## Timing
- Reset values:
  - player_hPos = H_START, player_vPos = V_START.
  - State PLAY, armed = 0.
  - level_count = 0, frozen = 0, new_level = 0.
  - All counters and synchronizer flops are 0.
- Button to position latency: a button held through a tick moves the position on the edge after the tick cycle. The button must be stable ≥ 2 cycles before the tick to be seen.
- level_complete is sampled on the clock edge. WIN_HOLD is entered, and frozen rises, on the following cycle.
- new_level and the start-position load happen in the same cycle. frozen is 0 from the next cycle onward.
- A reset asserted mid-hold or mid-move aborts immediately to the reset values. There is no partial update.

## Structure
- Shared package `game_pkg` holds:
  - the screen constants (H_LIM, V_LIM, STEP);
  - the 12-bit position type;
  - the FSM state enum {PLAY, WIN_HOLD, RESPAWN}.
- Natural sub-module: `tick_gen`, a parameterised divider with clear and enable that produces the one-cycle tick. The hold counter is a second instance with MOVE_DIV=HOLD_CYCLES.

## Test plan
All scenarios use MOVE_DIV=4, HOLD_CYCLES=6, STEP=8, H_LIM=24, V_LIM=16, start 0,0.
- Reset, then idle for 20 cycles -> position stays 0,0; level_count=0; new_level never pulses.
- Hold right for 5 ticks -> hPos goes 8, 16, 24, 24, 24 (clamped); vPos stays 0.
- Hold left at hPos=0, and hold up+down together -> position is unchanged across all ticks.
- Hold right+down for 2 ticks -> position becomes 16,16 (diagonal).
- Pulse level_complete while at 16,16:
  - frozen rises next cycle, level_count becomes 1;
  - buttons are ignored for 6 cycles;
  - then a single-cycle new_level with position 0,0;
  - then PLAY resumes.
- Hold level_complete high across the respawn -> no second win until level_complete drops for ≥1 cycle and rises again. Assert rst mid-hold -> every output returns to its reset value.

Source files
------------

// File: rtl/game_pkg.sv
// Shared maze-game types: screen limits, position type, player FSM states.
// Also holds the clamped one-axis step helper used by the player controller.
package game_pkg;

  localparam int POS_W     = 12;
  localparam int SCR_H_LIM = 632;
  localparam int SCR_V_LIM = 472;
  localparam int SCR_STEP  = 8;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    PLAY,
    WIN_HOLD,
    RESPAWN
  } state_e;

  // One axis: dec alone steps toward 0, inc alone steps toward lim,
  // both/neither hold. The 13-bit sum keeps the upper clamp wrap-free.
  function automatic pos_t step_axis(
    input pos_t p,
    input logic dec,
    input logic inc,
    input pos_t s,
    input pos_t lim
  );
    logic [POS_W:0] sum;
    pos_t           r;
    sum = {1'b0, p} + {1'b0, s};
    r   = p;
    if (dec && !inc) begin
      r = (p >= s) ? p - s : '0;
    end else if (inc && !dec) begin
      r = (sum <= {1'b0, lim}) ? sum[POS_W-1:0] : lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/player_ctrl_tick_gen.sv
// tick_gen: divider producing a one-cycle tick every DIV enabled cycles.
// Ports: clk_i, rst_i (async high), clr_i (sync clear), en_i, tick_o.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: stepped, screen-clamped player position with win freeze/respawn.
// In: clk, rst, btn_up/down/left/right, level_complete. Out: player_hPos/vPos,
// frozen, new_level, level_count.
module player_ctrl
  import game_pkg::*;
#(
  parameter int H_LIM       = SCR_H_LIM,
  parameter int V_LIM       = SCR_V_LIM,
  parameter int STEP        = SCR_STEP,
  parameter int MOVE_DIV    = 2_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int H_START     = 0,
  parameter int V_START     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        level_complete,
  output logic [11:0] player_hPos,
  output logic [11:0] player_vPos,
  output logic        frozen,
  output logic        new_level,
  output logic [3:0]  level_count
);

  // bit order: {right, left, down, up}
  logic [3:0] btn_s1_q, btn_s2_q;

  state_e     state_q, state_d;
  pos_t       h_q, h_d;
  pos_t       v_q, v_d;
  logic       armed_q, armed_d;
  logic [3:0] lvl_q, lvl_d;

  logic move_tick;
  logic hold_tick;
  logic win;
  logic in_play;
  logic in_hold;

  assign in_play = (state_q == PLAY);
  assign in_hold = (state_q == WIN_HOLD);
  assign win     = in_play && level_complete && armed_q;

  tick_gen #(.DIV(MOVE_DIV)) u_move (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (win),
    .en_i   (in_play),
    .tick_o (move_tick)
  );

  tick_gen #(.DIV(HOLD_CYCLES)) u_hold (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (!in_hold),
    .en_i   (in_hold),
    .tick_o (hold_tick)
  );

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    armed_d = armed_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      PLAY: begin
        if (!level_complete) armed_d = 1'b1;
        if (win) begin
          state_d = WIN_HOLD;
          armed_d = 1'b0;
          lvl_d   = lvl_q + 4'd1;
        end else if (move_tick) begin
          h_d = step_axis(h_q, btn_s2_q[2], btn_s2_q[3],
                          pos_t'(STEP), pos_t'(H_LIM));
          v_d = step_axis(v_q, btn_s2_q[0], btn_s2_q[1],
                          pos_t'(STEP), pos_t'(V_LIM));
        end
      end
      WIN_HOLD: begin
        // start position is loaded on the way into RESPAWN so it is
        // already visible in the new_level cycle
        if (hold_tick) begin
          state_d = RESPAWN;
          h_d     = pos_t'(H_START);
          v_d     = pos_t'(V_START);
        end
      end
      RESPAWN: state_d = PLAY;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      state_q  <= PLAY;
      h_q      <= pos_t'(H_START);
      v_q      <= pos_t'(V_START);
      armed_q  <= 1'b0;
      lvl_q    <= '0;
    end else begin
      btn_s1_q <= {btn_right, btn_left, btn_down, btn_up};
      btn_s2_q <= btn_s1_q;
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      armed_q  <= armed_d;
      lvl_q    <= lvl_d;
    end
  end

  assign player_hPos = h_q;
  assign player_vPos = v_q;
  assign frozen      = !in_play;
  assign new_level   = (state_q == RESPAWN);
  assign level_count = lvl_q;

endmodule
